// File: rtl/counter_sweep_pkg.sv
// Shared types for the counter sweep sequencer.
// SWEEP_PINGPONG_EN enables the StTurn state; it is unused in the default build.
package counter_sweep_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StTurn,
        StDone
    } sweep_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Command and counter-control bundle between the command layer, the sweep sequencer and the counter.
// SWEEP_PINGPONG_EN adds the bounces field.
interface counter_sweep_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] start_value;
    logic [WIDTH-1:0] end_value;
`ifdef SWEEP_PINGPONG_EN
    logic [3:0]       bounces;
`endif
    logic [WIDTH-1:0] count;
    logic             cnt_enable;
    logic             cnt_set;
    logic [WIDTH-1:0] cnt_set_value;
    logic             cnt_up_down;
    logic             busy;
    logic             done;

`ifdef SWEEP_PINGPONG_EN
    modport master (
        output start, abort, start_value, end_value, bounces, count,
        input  cnt_enable, cnt_set, cnt_set_value, cnt_up_down, busy, done
    );
    modport slave (
        input  start, abort, start_value, end_value, bounces, count,
        output cnt_enable, cnt_set, cnt_set_value, cnt_up_down, busy, done
    );
`else
    modport master (
        output start, abort, start_value, end_value, count,
        input  cnt_enable, cnt_set, cnt_set_value, cnt_up_down, busy, done
    );
    modport slave (
        input  start, abort, start_value, end_value, count,
        output cnt_enable, cnt_set, cnt_set_value, cnt_up_down, busy, done
    );
`endif

endinterface

// File: rtl/sweep_prescaler.sv
// Step-rate prescaler for the sweep sequencer: one tick every DIV cycles while run is high.
// Independent of SWEEP_PINGPONG_EN.
module sweep_prescaler #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= (cnt_q == Last) ? '0 : cnt_q + 1'b1;
        end
    end

    // With DIV=1 cnt_q never leaves 0, so tick follows run.
    assign tick = run && (cnt_q == Last);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequencer driving an up/down counter through a programmed sweep from start_value to end_value.
// SWEEP_PINGPONG_EN adds bounces and the StTurn leg reversal.
module counter_sweep_ctrl
    import counter_sweep_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 1
) (
    input logic                 clk,
    input logic                 reset,
    counter_sweep_ctrl_if.slave bus
);

    sweep_state_e     state_q;
    logic [WIDTH-1:0] origin_q;
    logic [WIDTH-1:0] target_q;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;
`ifdef SWEEP_PINGPONG_EN
    logic [3:0]       bounces_left_q;
`endif

    logic in_run;
    logic at_target;
    logic tick;

    assign in_run    = (state_q == StRun);
    assign at_target = (bus.count == target_q);

    // Holding the prescaler clear outside StRun gives a fresh phase on every entry to StRun.
    sweep_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_run),
        .run   (in_run),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            origin_q <= '0;
            target_q <= '0;
            dir_q    <= DIR_UP;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
            bounces_left_q <= 4'd0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        origin_q <= bus.start_value;
                        target_q <= bus.end_value;
                        dir_q    <= (bus.end_value >= bus.start_value) ? DIR_UP : DIR_DOWN;
`ifdef SWEEP_PINGPONG_EN
                        bounces_left_q <= bus.bounces;
`endif
                        busy_q   <= 1'b1;
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
`ifdef SWEEP_PINGPONG_EN
                    end else if (at_target && (bounces_left_q != 4'd0)) begin
                        state_q <= StTurn;
`endif
                    end else if (at_target) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
`ifdef SWEEP_PINGPONG_EN
                StTurn: begin
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        origin_q       <= target_q;
                        target_q       <= origin_q;
                        dir_q          <= ~dir_q;
                        bounces_left_q <= bounces_left_q - 4'd1;
                        state_q        <= StRun;
                    end
                end
`endif
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // abort masks the counter strobes in the very cycle it is raised.
    assign bus.cnt_set       = (state_q == StLoad) && !bus.abort;
    assign bus.cnt_enable    = in_run && tick && !at_target && !bus.abort;
    assign bus.cnt_set_value = (state_q == StLoad) ? origin_q : '0;
    assign bus.cnt_up_down   = dir_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule
